ex_wb_stage: RTL
================

Name: ex_wb_stage

Overview:
- Pipeline register between the execute stage and the write-back stage of the 3-stage MIPS core.
- Produces `registerWr`, write enable and write-back data. The forwarding unit compares `registerWr` against rs/rt of the following instruction; the register file consumes the write-back outputs.
- Handles multi-cycle loads with a ready handshake to data memory, stalls upstream while waiting, and aborts a hung load after a timeout.

Parameters:
- DATA_W, 32, data path width
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready before aborting a load (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX holds a real instruction this cycle
- ex_regWr  in  5  destination register of the EX instruction
- ex_reg_write  in  1  EX instruction writes the register file
- ex_mem_read  in  1  EX instruction is a load
- ex_alu_result  in  DATA_W  ALU result; doubles as load address, already presented to memory by EX
- flush  in  1  squash the EX instruction, or the pending load
- mem_rdata  in  DATA_W  load data, valid when mem_ready=1
- mem_ready  in  1  memory returns load data this cycle
- stall_out  out  1  hold PC and the EX inputs stable
- wb_valid  out  1  WB holds a completed instruction
- registerWr  out  5  WB destination; 0 whenever no write occurs
- wb_reg_write  out  1  register file write enable
- wb_data  out  DATA_W  register file write data
- fwd_valid  out  1  wb_valid & wb_reg_write; qualifies forwarding
- mem_error  out  1  sticky; set when a load times out

Behaviour:
- Reset (async, rst=1): state=RUN, wait counter=0.
  - Outputs: wb_valid=0, registerWr=0, wb_reg_write=0, wb_data=0, mem_error=0, stall_out=0.
- Write qualification: eff_write = ex_reg_write & (ex_regWr != 0). A write to $zero is never issued.
- Bubble: on any bubble cycle, wb_valid=0, wb_reg_write=0 and registerWr=0. wb_data holds its previous value.
- State RUN:
  - ex_valid=0 or flush=1: bubble next cycle.
  - ex_valid=1, flush=0, ex_mem_read=0: next edge loads wb_data=ex_alu_result, registerWr=eff_write?ex_regWr:0, wb_reg_write=eff_write, wb_valid=1. Latency is 1 cycle.
  - ex_valid=1, flush=0, ex_mem_read=1: latch the destination and eff_write internally, clear the counter, go to WAIT_MEM. Bubble next cycle.
- State WAIT_MEM:
  - stall_out = ~mem_ready & ~flush (combinational). EX inputs are ignored in this state.
  - mem_ready=1 (flush=0): next edge wb_data=mem_rdata, wb_valid=1, latched destination and write enable applied; go to RUN.
    - Same cycle, stall_out=0, so EX advances; its new instruction is captured on the following RUN cycle.
  - flush=1: abort, bubble, go to RUN. flush has priority over mem_ready when both are high.
  - Neither: counter increments.
    - Counter == MEM_TIMEOUT-1 with no mem_ready: set mem_error, abort (bubble), go to RUN, stall_out=0 that cycle.
    - mem_ready on the exact timeout cycle wins; the load completes normally.
- mem_error clears only on rst.
- fwd_valid is combinational from the registered outputs.
- Reset mid-WAIT_MEM: immediate return to RUN, stall_out drops asynchronously. A late mem_ready is ignored.
- Back-to-back ALU instructions: one completes every cycle, no stall.
- A load followed by an ALU instruction: the ALU instruction enters WB on the cycle after load data appears.

Test Plan:
1. Reset then ALU instruction:
   - Stimulus: ex_valid=1, ex_regWr=5, ex_reg_write=1, ex_alu_result=0x0000_0123.
   - Required: next cycle wb_valid=1, registerWr=5, wb_data=0x123, fwd_valid=1, stall_out=0.
2. Write to $zero and non-writing instruction:
   - Stimulus: ex_regWr=0, ex_reg_write=1; then ex_regWr=7, ex_reg_write=0.
   - Required: both cycles show registerWr=0, wb_reg_write=0, wb_valid=1, fwd_valid=0.
3. Load with 3-cycle memory:
   - Stimulus: ex_mem_read=1, ex_regWr=9; mem_ready rises on the 3rd WAIT_MEM cycle with mem_rdata=0xDEAD_BEEF.
   - Required: stall_out=1 for exactly 2 cycles, then 0. wb_valid=1, registerWr=9, wb_data=0xDEADBEEF one cycle after mem_ready.
4. Flush:
   - Flush an ALU instruction in RUN: bubble, registerWr=0.
   - Flush during WAIT_MEM with mem_ready=1 simultaneously: bubble, state RUN, no write.
5. Timeout, MEM_TIMEOUT=15:
   - Stimulus: load with mem_ready held 0.
   - Required: stall_out high 14 cycles; on the 15th cycle mem_error=1, stall_out=0, no write. mem_error stays 1 until rst.
   - Edge case: mem_ready on cycle 15 completes the load normally.
6. Async reset mid-load:
   - Stimulus: assert rst between clock edges during WAIT_MEM.
   - Required: outputs zero immediately; a subsequent mem_ready produces no write.

Source files
------------

// File: rtl/ex_wb_stage.sv
// EX/WB pipeline register for the 3-stage MIPS core. ALU results pass through in one
// cycle. Loads wait on a memory ready handshake, stall upstream, and abort on timeout.
module ex_wb_stage #(
    parameter int DATA_W      = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [4:0]        ex_regWr,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              flush,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_out,
    output logic              wb_valid,
    output logic [4:0]        registerWr,
    output logic              wb_reg_write,
    output logic [DATA_W-1:0] wb_data,
    output logic              fwd_valid,
    output logic              mem_error
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_e;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                wb_valid_q, wb_valid_d;
    logic [4:0]          reg_wr_q, reg_wr_d;
    logic                wb_reg_write_q, wb_reg_write_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                mem_error_q, mem_error_d;
    logic [4:0]          ld_dest_q, ld_dest_d;
    logic                ld_we_q, ld_we_d;

    logic eff_write;
    logic timeout_hit;

    // Writes to $zero are dropped here so downstream never sees them.
    assign eff_write   = ex_reg_write & (ex_regWr != 5'd0);
    assign timeout_hit = (cnt_q == TIMEOUT_LAST);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d        = state_q;
        cnt_d          = cnt_q;
        wb_valid_d     = 1'b0;
        reg_wr_d       = 5'd0;
        wb_reg_write_d = 1'b0;
        wb_data_d      = wb_data_q;
        mem_error_d    = mem_error_q;
        ld_dest_d      = ld_dest_q;
        ld_we_d        = ld_we_q;

        unique case (state_q)
            ST_RUN: begin
                if (ex_valid && !flush) begin
                    if (ex_mem_read) begin
                        ld_dest_d = eff_write ? ex_regWr : 5'd0;
                        ld_we_d   = eff_write;
                        cnt_d     = 8'd0;
                        state_d   = ST_WAIT_MEM;
                    end else begin
                        wb_valid_d     = 1'b1;
                        wb_data_d      = ex_alu_result;
                        reg_wr_d       = eff_write ? ex_regWr : 5'd0;
                        wb_reg_write_d = eff_write;
                    end
                end
            end
            ST_WAIT_MEM: begin
                // flush beats mem_ready; mem_ready beats the timeout on the same cycle.
                if (flush) begin
                    state_d = ST_RUN;
                end else if (mem_ready) begin
                    wb_valid_d     = 1'b1;
                    wb_data_d      = mem_rdata;
                    reg_wr_d       = ld_dest_q;
                    wb_reg_write_d = ld_we_q;
                    state_d        = ST_RUN;
                end else if (timeout_hit) begin
                    mem_error_d = 1'b1;
                    state_d     = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_RUN;
            cnt_q          <= 8'd0;
            wb_valid_q     <= 1'b0;
            reg_wr_q       <= 5'd0;
            wb_reg_write_q <= 1'b0;
            wb_data_q      <= '0;
            mem_error_q    <= 1'b0;
            ld_dest_q      <= 5'd0;
            ld_we_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wb_valid_q     <= wb_valid_d;
            reg_wr_q       <= reg_wr_d;
            wb_reg_write_q <= wb_reg_write_d;
            wb_data_q      <= wb_data_d;
            mem_error_q    <= mem_error_d;
            ld_dest_q      <= ld_dest_d;
            ld_we_q        <= ld_we_d;
        end
    end

    // Stall drops on the timeout cycle so EX can advance while the load is aborted.
    assign stall_out    = (state_q == ST_WAIT_MEM) & ~mem_ready & ~flush & ~timeout_hit;
    assign wb_valid     = wb_valid_q;
    assign registerWr   = reg_wr_q;
    assign wb_reg_write = wb_reg_write_q;
    assign wb_data      = wb_data_q;
    assign fwd_valid    = wb_valid_q & wb_reg_write_q;
    assign mem_error    = mem_error_q;

endmodule
